// File: rtl/bfp_pkg.sv
// -----------------------------------------------------------------------------
// bfp_pkg
// Shared definitions for the block-floating-point decoder path.
//   - shw(width): width of a shift factor able to hold 0..width.
//   - bfp_dec_state_e: decoder FSM states (waiting for a shift / inside a block).
// -----------------------------------------------------------------------------
package bfp_pkg;

  // Number of bits needed to carry a shift in the inclusive range 0..width.
  function automatic int shw(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    BLOCK = 1'b1
  } bfp_dec_state_e;

endpackage

// File: rtl/bfp_denorm_shift.sv
// -----------------------------------------------------------------------------
// bfp_denorm_shift
// Combinational restore of one normalized mantissa to a fixed-point magnitude:
//   ext     = {mantissa, (WIDTH-MANT_W) zeros}
//   o_value = ext >> i_shift
// A shift of WIDTH yields zero (zero-block code).
//
// Build option: BFP_DEC_ROUND_EN
//   defined   -> round half-up: the last bit shifted out is added back when
//                1 <= shift < WIDTH. The shifted value is below 2^(WIDTH-shift),
//                so the increment can never overflow WIDTH bits.
//   undefined -> truncate (plain right shift).
//
// Ports
//   i_mant   in  MANT_W  unsigned normalized mantissa
//   i_shift  in  SHW     shift factor, already limited to 0..WIDTH
//   o_value  out WIDTH   restored magnitude
// -----------------------------------------------------------------------------
module bfp_denorm_shift #(
  parameter int WIDTH  = 16,
  parameter int MANT_W = 8,
  parameter int SHW    = 5
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic [SHW-1:0]    i_shift,
  output logic [WIDTH-1:0]  o_value
);

  logic [WIDTH-1:0] w_ext;
  logic [WIDTH-1:0] w_shifted;

  // Left-align the mantissa in the output word; works for MANT_W == WIDTH too.
  assign w_ext     = WIDTH'(i_mant) << (WIDTH - MANT_W);
  assign w_shifted = w_ext >> i_shift;

`ifdef BFP_DEC_ROUND_EN
  logic             w_round_en;
  logic [WIDTH-1:0] w_below;
  logic             w_round_bit;

  assign w_round_en  = (i_shift != '0) && (i_shift < SHW'(WIDTH));
  // Bit (shift-1) of ext is the most significant discarded bit. The shift
  // wraps when i_shift is 0, but the result is gated off in that case.
  assign w_below     = w_ext >> (i_shift - 1'b1);
  assign w_round_bit = w_round_en & w_below[0];
  assign o_value     = w_shifted + WIDTH'(w_round_bit);
`else
  assign o_value     = w_shifted;
`endif

endmodule

// File: rtl/bfp_block_decoder.sv
// -----------------------------------------------------------------------------
// bfp_block_decoder
// Decoder side of the block-floating-point path. Accepts one shift factor per
// block, then that block's mantissas, and emits restored fixed-point magnitudes
// through a single output register (1-cycle latency, 1 beat/clk when o_ready=1).
//
// Build option: BFP_DEC_ROUND_EN selects round half-up in bfp_denorm_shift;
// the default build truncates.
//
// Ports
//   clk        in   1       clock
//   rst_n      in   1       asynchronous active-low reset
//   exp_valid  in   1       shift factor offered
//   exp_ready  out  1       shift factor accepted (IDLE only)
//   exp_in     in   SHW     shift factor, values above WIDTH clamp to WIDTH
//   m_valid    in   1       mantissa offered
//   m_ready    out  1       mantissa accepted (BLOCK and output slot free)
//   m_data     in   MANT_W  unsigned normalized mantissa
//   m_last     in   1       final mantissa of the block
//   o_valid    out  1       restored sample valid
//   o_ready    in   1       downstream ready
//   o_data     out  WIDTH   restored unsigned magnitude
//   o_last     out  1       final sample of the block
//   len_err    out  1       one-cycle pulse on a block-length violation
// -----------------------------------------------------------------------------
module bfp_block_decoder
  import bfp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MANT_W    = 8,
  parameter int BLOCK_LEN = 64,
  localparam int SHW      = shw(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [SHW-1:0]    exp_in,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [MANT_W-1:0] m_data,
  input  logic              m_last,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_last,
  output logic              len_err
);

  // Beat counter spans 0..BLOCK_LEN. The value BLOCK_LEN is the saturated
  // "overrun already reported" state, so a long block pulses len_err once.
  localparam int              CNTW     = $clog2(BLOCK_LEN + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLOCK_LEN - 1);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(BLOCK_LEN);
  localparam logic [SHW-1:0]  SH_MAX   = SHW'(WIDTH);

  bfp_dec_state_e    r_state;
  logic [SHW-1:0]    r_shift;
  logic [CNTW-1:0]   r_beat_cnt;
  logic              r_o_valid;
  logic [WIDTH-1:0]  r_o_data;
  logic              r_o_last;
  logic              r_len_err;

  logic              w_exp_ready;
  logic              w_m_ready;
  logic              w_exp_accept;
  logic              w_m_accept;
  logic [SHW-1:0]    w_shift_clamped;
  logic [WIDTH-1:0]  w_restored;

  assign w_exp_ready     = (r_state == IDLE);
  // The output slot is free when empty or being drained this cycle.
  assign w_m_ready       = (r_state == BLOCK) && (!r_o_valid || o_ready);
  assign w_exp_accept    = exp_valid && w_exp_ready;
  assign w_m_accept      = m_valid && w_m_ready;
  assign w_shift_clamped = (exp_in > SH_MAX) ? SH_MAX : exp_in;

  bfp_denorm_shift #(
    .WIDTH  (WIDTH),
    .MANT_W (MANT_W),
    .SHW    (SHW)
  ) u_denorm (
    .i_mant  (m_data),
    .i_shift (r_shift),
    .o_value (w_restored)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_beat_cnt <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_last   <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_len_err <= 1'b0;

      // Drain; a load below in the same cycle takes precedence.
      if (r_o_valid && o_ready) begin
        r_o_valid <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (w_exp_accept) begin
            r_shift    <= w_shift_clamped;
            r_beat_cnt <= '0;
            r_state    <= BLOCK;
          end
        end

        BLOCK: begin
          if (w_m_accept) begin
            r_o_valid <= 1'b1;
            r_o_data  <= w_restored;
            r_o_last  <= m_last;
            if (m_last) begin
              // Short block flags here; an overrun was already flagged.
              if ((r_beat_cnt != CNT_LAST) && (r_beat_cnt != CNT_SAT)) begin
                r_len_err <= 1'b1;
              end
              r_state <= IDLE;
            end else if (r_beat_cnt != CNT_SAT) begin
              // Non-last beat at the block's final slot is an overrun.
              if (r_beat_cnt == CNT_LAST) begin
                r_len_err <= 1'b1;
              end
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign exp_ready = w_exp_ready;
  assign m_ready   = w_m_ready;
  assign o_valid   = r_o_valid;
  assign o_data    = r_o_data;
  assign o_last    = r_o_last;
  assign len_err   = r_len_err;

endmodule

// File: tb/tb_bfp_block_decoder.sv
// -----------------------------------------------------------------------------
// tb_bfp_block_decoder
// Directed vectors with hand-computed expectations for bfp_block_decoder
// (WIDTH=16, MANT_W=8, BLOCK_LEN=4). Inputs change on the falling edge, DUT
// outputs are read shortly after the falling edge.
// -----------------------------------------------------------------------------
module tb_bfp_block_decoder;

  localparam int WIDTH     = 16;
  localparam int MANT_W    = 8;
  localparam int BLOCK_LEN = 4;
  localparam int SHW       = 5;

  logic              clk;
  logic              rst_n;
  logic              exp_valid;
  logic              exp_ready;
  logic [SHW-1:0]    exp_in;
  logic              m_valid;
  logic              m_ready;
  logic [MANT_W-1:0] m_data;
  logic              m_last;
  logic              o_valid;
  logic              o_ready;
  logic [WIDTH-1:0]  o_data;
  logic              o_last;
  logic              len_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] mon_q[$];

  bfp_block_decoder #(
    .WIDTH     (WIDTH),
    .MANT_W    (MANT_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_in    (exp_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_last    (o_last),
    .len_err   (len_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Output monitor: one line per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && o_valid && o_ready) begin
        mon_q.push_back({o_last, o_data});
        $display("tb: out data=%h last=%b", o_data, o_last);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_exp(input logic [SHW-1:0] e);
    int t = 0;
    exp_valid = 1'b1;
    exp_in    = e;
    #1;
    while (!exp_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!exp_ready) chk("exp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [MANT_W-1:0] d, input logic l);
    int t = 0;
    m_valid = 1'b1;
    m_data  = d;
    m_last  = l;
    #1;
    while (!m_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!m_ready) chk("beat_timeout", 32'd0, 32'd1);
    @(negedge clk);
    m_valid = 1'b0;
    m_last  = 1'b0;
  endtask

  initial begin
    logic [7:0]  basic_m [4];
    logic [15:0] basic_o [4];
    logic [16:0] bp_exp  [4];
    logic [16:0] got;

    basic_m = '{8'hB4, 8'h80, 8'h01, 8'hFF};
    basic_o = '{16'h1680, 16'h1000, 16'h0020, 16'h1FE0};
    bp_exp  = '{17'h00440, 17'h00880, 17'h00CC0, 17'h11100};

    rst_n     = 1'b0;
    exp_valid = 1'b0;
    exp_in    = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    o_ready   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_valid",   32'(o_valid),   32'd0);
    chk("rst_o_data",    32'(o_data),    32'd0);
    chk("rst_o_last",    32'(o_last),    32'd0);
    chk("rst_len_err",   32'(len_err),   32'd0);
    chk("rst_exp_ready", 32'(exp_ready), 32'd1);
    chk("rst_m_ready",   32'(m_ready),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic decode, shift 3
    send_exp(5'd3);
    #1;
    chk("basic_pre_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_beat(basic_m[i], i == 3);
      #1;
      chk("basic_valid", 32'(o_valid), 32'd1);
      chk("basic_data",  32'(o_data),  32'(basic_o[i]));
      chk("basic_last",  32'(o_last),  (i == 3) ? 32'd1 : 32'd0);
      chk("basic_len_err", 32'(len_err), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("basic_drained",   32'(o_valid),   32'd0);
    chk("basic_exp_ready", 32'(exp_ready), 32'd1);

    // Rounding and zero-block / clamp handling (single-beat blocks)
    send_exp(5'd9);
    send_beat(8'hFF, 1'b1);
    #1;
`ifdef BFP_DEC_ROUND_EN
    chk("round_exp9", 32'(o_data), 32'h0080);
`else
    chk("round_exp9", 32'(o_data), 32'h007F);
`endif
    send_exp(5'd16);
    send_beat(8'hFF, 1'b1);
    #1;
    chk("zero_exp16", 32'(o_data), 32'h0000);
    send_exp(5'd0);
    send_beat(8'hFF, 1'b1);
    #1;
    chk("exp0", 32'(o_data), 32'hFF00);
    send_exp(5'd31);
    send_beat(8'h80, 1'b1);
    #1;
    chk("clamp_exp31", 32'(o_data), 32'h0000);
    @(negedge clk);

    // Backpressure, shift 2
    mon_q.delete();
    send_exp(5'd2);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    o_ready = 1'b0;
    m_valid = 1'b1;
    m_data  = 8'h33;
    m_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_m_ready", 32'(m_ready), 32'd0);
      chk("bp_valid",   32'(o_valid), 32'd1);
      chk("bp_data",    32'(o_data),  32'h0880);
      chk("bp_last",    32'(o_last),  32'd0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    chk("bp_count", 32'(mon_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (mon_q.size() > 0) ? mon_q.pop_front() : 17'h1FFFF;
      chk("bp_order", 32'(got), 32'(bp_exp[i]));
    end

    // Short block: last on beat 2
    send_exp(5'd0);
    send_beat(8'h01, 1'b0);
    #1;
    chk("short_b1_err", 32'(len_err), 32'd0);
    send_beat(8'h02, 1'b1);
    #1;
    chk("short_err", 32'(len_err), 32'd1);
    @(negedge clk);
    #1;
    chk("short_err_once", 32'(len_err),   32'd0);
    chk("short_idle",     32'(exp_ready), 32'd1);

    // Long block: 6 beats, error only on beat 4
    send_exp(5'd0);
    for (int i = 0; i < 6; i++) begin
      send_beat(8'(i + 1), i == 5);
      #1;
      chk("long_err", 32'(len_err), (i == 3) ? 32'd1 : 32'd0);
      chk("long_data", 32'(o_data), 32'((i + 1) << 8));
    end
    @(negedge clk);
    #1;
    chk("long_idle", 32'(exp_ready), 32'd1);

    // Back-to-back blocks with exp_valid held high
    send_exp(5'd1);
    exp_valid = 1'b1;
    exp_in    = 5'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b2b_blk_exp_ready", 32'(exp_ready), 32'd0);
      send_beat(8'h80, i == 3);
      #1;
      chk("b2b_blk1_data", 32'(o_data), 32'h4000);
    end
    chk("b2b_exp_ready_after_last", 32'(exp_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b_exp_taken", 32'(exp_ready), 32'd0);
    exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(8'h80, i == 3);
      #1;
      chk("b2b_blk2_data", 32'(o_data), 32'h0400);
      chk("b2b_blk2_err",  32'(len_err), 32'd0);
    end
    @(negedge clk);

    // Reset mid-block
    send_exp(5'd4);
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_o_valid",   32'(o_valid),   32'd0);
    chk("mrst_exp_ready", 32'(exp_ready), 32'd1);
    chk("mrst_m_ready",   32'(m_ready),   32'd0);
    chk("mrst_o_data",    32'(o_data),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_exp(5'd4);
    for (int i = 0; i < 4; i++) begin
      send_beat(8'hF0, i == 3);
      #1;
      chk("mrst_data",    32'(o_data),  32'h0F00);
      chk("mrst_last",    32'(o_last),  (i == 3) ? 32'd1 : 32'd0);
      chk("mrst_len_err", 32'(len_err), 32'd0);
    end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
